// File: rtl/bash_perm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bash_hash_params_pkg
//  Description : Shared types and constants for the bash-f permutation
//                sequencer. Holds the sequencer state encoding, the default
//                round count and the round index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package bash_hash_params_pkg;

    localparam int NUM_ROUNDS_DEFAULT = 24;
    localparam int ROUND_IDX_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LOADED  = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } perm_state_t;

endpackage
`default_nettype wire

// File: rtl/bash_perm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bash_perm_ctrl_if
//  Description : Strobe/status bundle between the register map, the bash-f
//                core and the permutation sequencer.
//                slave  : sequencer side (receives prep/start, drives status)
//                master : register-map / core side
//  Ports       : prep_i, start_i           - one-cycle command strobes
//                load_o, capture_o         - one-cycle core control pulses
//                round_en_o, round_idx_o   - core round enable and index
//                active_o, rdy_o, err_o    - status back to the register map
//                cyc_cnt_o                 - cycle counter (zero if disabled)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bash_perm_ctrl_if #(
    parameter int CNT_W = 32
);
    import bash_hash_params_pkg::*;

    logic                   prep_i;
    logic                   start_i;
    logic                   load_o;
    logic                   round_en_o;
    logic [ROUND_IDX_W-1:0] round_idx_o;
    logic                   capture_o;
    logic                   active_o;
    logic                   rdy_o;
    logic                   err_o;
    logic [CNT_W-1:0]       cyc_cnt_o;

    modport slave (
        input  prep_i, start_i,
        output load_o, round_en_o, round_idx_o, capture_o,
               active_o, rdy_o, err_o, cyc_cnt_o
    );

    modport master (
        output prep_i, start_i,
        input  load_o, round_en_o, round_idx_o, capture_o,
               active_o, rdy_o, err_o, cyc_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/bash_perm_ctrl_round_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bash_round_cnt
//  Description : Sub-cycle and round counter. While run_i is high the
//                sub-cycle counter walks 0..CYCLES_PER_ROUND-1; on its last
//                value round_en_o fires and the round index advances, wrapping
//                to 0 after the final round. Both counters hold at 0 while
//                run_i is low, so the round index is 0 outside a run.
//  Ports       : clk_i, rst_i (async, active-high), run_i,
//                round_en_o, round_idx_o, last_o (round_en on final round)
//  Revision    : 1.0 - initial release
// ============================================================================
module bash_round_cnt
    import bash_hash_params_pkg::*;
#(
    parameter int NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
    parameter int CYCLES_PER_ROUND = 1
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   run_i,
    output logic                        round_en_o,
    output logic [ROUND_IDX_W-1:0]      round_idx_o,
    output logic                        last_o
);

    // A one-cycle round still needs a one-bit counter to stay legal.
    localparam int SUB_W = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
    localparam logic [SUB_W-1:0]       C_SUB_LAST = SUB_W'(CYCLES_PER_ROUND - 1);
    localparam logic [ROUND_IDX_W-1:0] C_IDX_LAST = ROUND_IDX_W'(NUM_ROUNDS - 1);

    logic [SUB_W-1:0]       r_sub;
    logic [ROUND_IDX_W-1:0] r_idx;
    logic                   w_round_en;

    assign w_round_en = run_i && (r_sub == C_SUB_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sub <= '0;
            r_idx <= '0;
        end else if (!run_i) begin
            r_sub <= '0;
            r_idx <= '0;
        end else if (w_round_en) begin
            r_sub <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_sub <= r_sub + 1'b1;
        end
    end

    assign round_en_o  = w_round_en;
    assign round_idx_o = r_idx;
    assign last_o      = w_round_en && (r_idx == C_IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/bash_perm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bash_perm_ctrl
//  Description : Sequencer for the round-iterated bash-f permutation core.
//                Turns prep/start strobes into load / run-rounds / capture.
//                A start from DONE re-permutes the current core state
//                (sponge chaining without reload).
//  Ports       : clk_i, rst_i (async, active-high), bus (bash_perm_ctrl_if
//                slave modport: prep/start in; load, round_en, round_idx,
//                capture, active, rdy, err, cyc_cnt out)
//  Options     : BASH_PERM_CTRL_CYC_CNT_EN - adds a saturating cycle counter
//                on cyc_cnt_o; when undefined cyc_cnt_o is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module bash_perm_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
    parameter int CYCLES_PER_ROUND = 1,
    parameter int CNT_W            = 32
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    bash_perm_ctrl_if.slave  bus
);

    perm_state_t            r_state;
    logic                   r_load;
    logic                   r_capture;
    logic                   r_err;
    logic                   w_run;
    logic                   w_round_en;
    logic                   w_last;
    logic [ROUND_IDX_W-1:0] w_round_idx;
    logic                   w_strobe;

    assign w_run    = (r_state == ST_RUN);
    assign w_strobe = bus.prep_i || bus.start_i;

    bash_round_cnt #(
        .NUM_ROUNDS       (NUM_ROUNDS),
        .CYCLES_PER_ROUND (CYCLES_PER_ROUND)
    ) u_round_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .run_i       (w_run),
        .round_en_o  (w_round_en),
        .round_idx_o (w_round_idx),
        .last_o      (w_last)
    );

    // load/capture are set on the transition into LOAD/CAPTURE so they are
    // high for exactly the one cycle spent in that state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_load    <= 1'b0;
            r_capture <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_load    <= 1'b0;
            r_capture <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.prep_i) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        // Accepted prep clears the flag, unless a start
                        // collided with it in the same cycle.
                        r_err   <= bus.start_i;
                    end else if (bus.start_i) begin
                        r_err   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_LOADED;
                    if (w_strobe) r_err <= 1'b1;
                end
                ST_LOADED, ST_DONE: begin
                    if (bus.prep_i) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        r_err   <= bus.start_i;
                    end else if (bus.start_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_strobe) r_err <= 1'b1;
                    if (w_last) begin
                        r_state   <= ST_CAPTURE;
                        r_capture <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_DONE;
                    if (w_strobe) r_err <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.load_o      = r_load;
    assign bus.capture_o   = r_capture;
    assign bus.err_o       = r_err;
    assign bus.round_en_o  = w_round_en;
    assign bus.round_idx_o = w_round_idx;
    assign bus.active_o    = (r_state == ST_RUN) || (r_state == ST_CAPTURE);
    assign bus.rdy_o       = (r_state == ST_DONE);

`ifdef BASH_PERM_CTRL_CYC_CNT_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic             w_start_acc;

    assign w_start_acc = ((r_state == ST_LOADED) || (r_state == ST_DONE))
                         && bus.start_i && !bus.prep_i;

    // Counts RUN+CAPTURE cycles, freezes in DONE, saturates instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cyc_cnt <= '0;
        end else if (w_start_acc) begin
            r_cyc_cnt <= '0;
        end else if (bus.active_o && (r_cyc_cnt != {CNT_W{1'b1}})) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
        end
    end

    assign bus.cyc_cnt_o = r_cyc_cnt;
`else
    assign bus.cyc_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
